// File: rtl/video_timing_pkg.sv
// Shared timing definitions for the DVI raster path: 640x480@60 mode values,
// total-count helpers, sync polarity constants and the timing tuple type.
package video_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Flags are active-high here; output polarity is applied at the very end.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  localparam timing_t TIMING_IDLE = '0;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_delay_line.sv
// ce-qualified shift register of timing tuples; resets every stage to the idle tuple.
module timing_delay_line
  import video_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    ce,
  input  timing_t d,
  output timing_t q
);

  timing_t stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= TIMING_IDLE;
    end else if (ce) begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, line/frame strobes, and pipelined
// hsync/vsync/de aligned to pixel data derived from x/y.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          H_ACTIVE = VGA_H_ACTIVE,
  parameter int          H_FP     = VGA_H_FP,
  parameter int          H_SYNC   = VGA_H_SYNC,
  parameter int          H_BP     = VGA_H_BP,
  parameter int          V_ACTIVE = VGA_V_ACTIVE,
  parameter int          V_FP     = VGA_V_FP,
  parameter int          V_SYNC   = VGA_V_SYNC,
  parameter int          V_BP     = VGA_V_BP,
  parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned PIPE_DLY = 2,
  parameter int          CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  timing_t raw;
  timing_t dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (ce) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_comb begin
    raw    = TIMING_IDLE;
    raw.de = (x < X_ACT) && (y < Y_ACT);
    raw.hs = (x >= HS_START) && (x < HS_END);
    raw.vs = (y >= VS_START) && (y < VS_END);
  end

  timing_delay_line #(
    .DEPTH(PIPE_DLY)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .d    (raw),
    .q    (dly_q)
  );

  // Counters already sit at (0,0) during reset, so strobes are masked by reset
  // to keep them low until the first pixel is actually live.
  assign line_start  = !reset && (x == '0);
  assign frame_start = line_start && (y == '0);

  assign de    = dly_q.de;
  assign hsync = dly_q.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync = dly_q.vs ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a reduced-mode
// instance share stimulus and are compared against an arithmetic raster model.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;

  logic [11:0] a_x, a_y;
  logic        a_fs, a_ls, a_hs, a_vs, a_de;
  logic [5:0]  b_x, b_y;
  logic        b_fs, b_ls, b_hs, b_vs, b_de;

  int checks = 0;
  int errors = 0;
  longint n = 0;

  always #5 clk = ~clk;

  video_timing_gen u_dut_a (
    .clk(clk), .reset(reset), .ce(ce), .x(a_x), .y(a_y),
    .frame_start(a_fs), .line_start(a_ls), .hsync(a_hs), .vsync(a_vs), .de(a_de)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DLY(3), .CW(6)
  ) u_dut_b (
    .clk(clk), .reset(reset), .ce(ce), .x(b_x), .y(b_y),
    .frame_start(b_fs), .line_start(b_ls), .hsync(b_hs), .vsync(b_vs), .de(b_de)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // n = number of pixels elapsed since reset; the raster is just n taken modulo
  // the frame size, and the delayed outputs describe pixel n-dly.
  function automatic void model(input longint cnt, input int ha, input int hf, input int hs,
                                input int hb, input int va, input int vf, input int vs,
                                input int vb, input int dly, input bit pol,
                                output longint ex, output longint ey,
                                output bit ede, output bit ehs, output bit evs);
    longint ht, vt, p, d, dx, dy;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = cnt % (ht * vt);
    ex = p % ht;
    ey = p / ht;
    if (cnt < dly) begin
      ede = 1'b0; ehs = ~pol; evs = ~pol;
    end else begin
      d  = (cnt - dly) % (ht * vt);
      dx = d % ht;
      dy = d / ht;
      ede = (dx < ha) && (dy < va);
      ehs = (dx >= ha + hf && dx < ha + hf + hs) ? pol : ~pol;
      evs = (dy >= va + vf && dy < va + vf + vs) ? pol : ~pol;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) n = 0;
    else if (ce) n++;
  end

  always @(negedge clk) begin
    longint ex, ey;
    bit ede, ehs, evs;
    model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, ex, ey, ede, ehs, evs);
    chk("A.x", a_x, ex);
    chk("A.y", a_y, ey);
    chk("A.line_start", a_ls, longint'(ex == 0 && !reset));
    chk("A.frame_start", a_fs, longint'(ex == 0 && ey == 0 && !reset));
    chk("A.de", a_de, ede);
    chk("A.hsync", a_hs, ehs);
    chk("A.vsync", a_vs, evs);
    model(n, 16, 4, 6, 6, 12, 2, 3, 3, 3, 1'b1, ex, ey, ede, ehs, evs);
    chk("B.x", b_x, ex);
    chk("B.y", b_y, ey);
    chk("B.line_start", b_ls, longint'(ex == 0 && !reset));
    chk("B.frame_start", b_fs, longint'(ex == 0 && ey == 0 && !reset));
    chk("B.de", b_de, ede);
    chk("B.hsync", b_hs, ehs);
    chk("B.vsync", b_vs, evs);
  end

  // Pulse-width and period measurements, in clk cycles.
  int de_cnt, de_run, hs_cnt, hs_run, lp_cnt, line_per;
  int vs_cnt, vs_run, fp_cnt, frame_per, ls_cnt, lines_per_frame;
  logic a_ls_q, b_ls_q, b_fs_q;

  always @(negedge clk) begin
    if (reset) begin
      de_cnt = 0; hs_cnt = 0; lp_cnt = 0; vs_cnt = 0; fp_cnt = 0; ls_cnt = 0;
      a_ls_q = 1'b0; b_ls_q = 1'b0; b_fs_q = 1'b0;
    end else begin
      if (a_de) de_cnt++;
      else begin if (de_cnt != 0) de_run = de_cnt; de_cnt = 0; end
      if (!a_hs) hs_cnt++;
      else begin if (hs_cnt != 0) hs_run = hs_cnt; hs_cnt = 0; end
      if (a_ls && !a_ls_q) begin line_per = lp_cnt; lp_cnt = 1; end
      else lp_cnt++;
      if (b_vs) vs_cnt++;
      else begin if (vs_cnt != 0) vs_run = vs_cnt; vs_cnt = 0; end
      if (b_fs && !b_fs_q) begin
        frame_per = fp_cnt; fp_cnt = 1;
        lines_per_frame = ls_cnt; ls_cnt = 0;
      end else fp_cnt++;
      if (b_ls && !b_ls_q) ls_cnt++;
      a_ls_q = a_ls; b_ls_q = b_ls; b_fs_q = b_fs;
    end
  end

  task automatic clear_meas();
    de_run = 0; hs_run = 0; line_per = 0; vs_run = 0; frame_per = 0; lines_per_frame = 0;
  endtask

  task automatic check_meas(input int k);
    chk("A.de_run", de_run, 640 * k);
    chk("A.hsync_low_run", hs_run, 96 * k);
    chk("A.line_period", line_per, 800 * k);
    chk("B.vsync_run", vs_run, 96 * k);
    chk("B.frame_period", frame_per, 640 * k);
    chk("B.lines_per_frame", lines_per_frame, 20);
  endtask

  task automatic restart_checks();
    chk("restart.frame_start", a_fs, 1);
    @(posedge clk); #1;
    chk("restart.x_first", a_x, 1);
    chk("restart.de_lat1", a_de, 0);
    @(posedge clk); #1;
    chk("restart.x_second", a_x, 2);
    chk("restart.de_lat2", a_de, 1);
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst.x", a_x, 0);
    chk("rst.y", a_y, 0);
    chk("rst.de", a_de, 0);
    chk("rst.hsync", a_hs, 1);
    chk("rst.vsync", a_vs, 1);
    chk("rst.line_start", a_ls, 0);
    chk("rst.frame_start", a_fs, 0);
    chk("rst.B.hsync", b_hs, 0);
    reset = 1'b0;
    #1;
    restart_checks();

    clear_meas();
    repeat (2500) @(posedge clk);
    #1;
    check_meas(1);

    clear_meas();
    repeat (5200) begin
      @(posedge clk); #1;
      ce = ~ce;
    end
    check_meas(2);

    repeat (3000) begin
      @(posedge clk); #1;
      ce = 1'($urandom_range(0, 1));
    end

    // Async reset in the middle of an hsync pulse.
    ce = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (700) @(posedge clk);
    #3;
    chk("mid.x_before", a_x, 700);
    chk("mid.hsync_before", a_hs, 0);
    reset = 1'b1;
    #1;
    chk("mid.hsync_async", a_hs, 1);
    chk("mid.de_async", a_de, 0);
    chk("mid.x_async", a_x, 0);
    chk("mid.y_async", a_y, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    restart_checks();

    repeat (50) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
